dual_rail_collector: RTL and testbench
======================================

Name: dual_rail_collector

Overview:
Downstream consumer of the dual-rail (true/false rail pair) gate network used in the AES datapath countermeasures. Sequences precharge/evaluate phases for the upstream network, waits for evaluation to complete on every bit, and converts the dual-rail word back to a registered single-rail word. Detects illegal rail codes and phase timeouts, which indicate a fault injection or a broken network, and reports them as sticky faults.

Parameters:
WIDTH, 8, number of dual-rail bits collected.
PRE_CYCLES, 1, consecutive all-zero cycles required before leaving precharge (>=1).
TIMEOUT, 15, maximum extra cycles allowed in PRECHARGE or EVAL before a fault (>=1).

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  request one evaluation; accepted only in IDLE.
clear  in  1  leave FAULT; ignored in other states.
din_t  in  WIDTH  true rails from the gate network.
din_f  in  WIDTH  false rails from the gate network.
precharge  out  1  1 = upstream drives all rails to 00; 0 = evaluate.
dout  out  WIDTH  captured single-rail result.
dout_valid  out  1  one-cycle pulse when dout is updated.
busy  out  1  1 in PRECHARGE, EVAL and DONE.
fault  out  1  sticky fault flag.
fault_code  out  2  00 none, 01 illegal code (11), 10 eval timeout, 11 precharge timeout.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, precharge=1, dout=0, dout_valid=0, busy=0, fault=0, fault_code=00, counters=0. Reset wins over every other input in any state.
- Per-bit decode: bit valid when exactly one rail is 1; the word is complete when all bits are valid. The word is zero when all rails are 0. The word is illegal when any bit has both rails at 1.
- precharge is 0 only in EVAL and 1 in every other state. dout_valid is 1 only in DONE.
- IDLE: if start=1, go to PRECHARGE and clear both counters.
- PRECHARGE: zcnt counts consecutive zero-word cycles and resets to 0 on any non-zero word. tcnt increments every cycle.
  - When zcnt reaches PRE_CYCLES-1 and the word is zero, go to EVAL with tcnt=0.
  - Otherwise, when tcnt==TIMEOUT, go to FAULT with code 11.
- EVAL: checks are applied in this priority order.
  - Illegal word: go to FAULT with code 01 (wins over completion in the same cycle).
  - Complete word: dout <= din_t and go to DONE.
  - tcnt==TIMEOUT: go to FAULT with code 10.
  - Otherwise tcnt increments.
  - A partial word (some bits still 00) is not an error while time remains.
- DONE: lasts one cycle, then goes to IDLE. start in DONE is ignored; start is not queued.
- FAULT: fault=1, fault_code is held, busy=0 and precharge=1. dout keeps its last good value. clear=1 goes to IDLE and zeroes fault and fault_code. start is ignored.
- start while busy is ignored.
- Latency with PRE_CYCLES=1 and ideal rails: start sampled in cycle 0, PRECHARGE in cycle 1, EVAL in cycle 2 (precharge=0). The complete word is sampled in cycle 2 and dout_valid=1 in cycle 3. Minimum start-to-result latency is 3 cycles.
- Counter widths are clog2(max(PRE_CYCLES,TIMEOUT)+1); counters never wrap because the state changes at TIMEOUT.
- din_t/din_f are sampled synchronously; the upstream network is in the clk domain.

Decomposition:
- Shared package (dual_rail_pkg): state encoding (IDLE, PRECHARGE, EVAL, DONE, FAULT), fault code constants (FC_NONE, FC_ILLEGAL, FC_EVAL_TO, FC_PRE_TO).
- One combinational sub-module, dual_rail_detect (parameter WIDTH; inputs din_t, din_f; outputs complete, zero, illegal), reusable by other dual-rail stages.
- The FSM, counters and output registers live in dual_rail_collector.

Test Plan:
- Nominal: reset, start; rails 00 in PRECHARGE, then din_t=8'hA5, din_f=8'h5A from the EVAL entry cycle -> dout=8'hA5, dout_valid pulses exactly once 3 cycles after start, fault=0.
- Slow evaluation: in EVAL, bits arrive one per cycle over 8 cycles (TIMEOUT=15) -> no fault, dout_valid on the cycle after the last bit; precharge=0 throughout EVAL.
- Illegal code: in EVAL drive din_t=8'h01, din_f=8'hFF (bit0 = 11) together with otherwise-complete rails -> FAULT, fault_code=01, no dout_valid, dout unchanged; clear=1 -> IDLE, fault=0.
- Eval timeout: rails stay 00 in EVAL -> FAULT with code 10 exactly TIMEOUT+1 cycles after EVAL entry.
- Precharge timeout: din_t=8'h01 held through PRECHARGE -> FAULT with code 11 after TIMEOUT+1 cycles. With PRE_CYCLES=3 and a zero word broken once, zcnt restarts and EVAL entry is delayed accordingly.
- Reset mid-operation and start while busy: rst_n=0 during EVAL -> next cycle all outputs take reset values. A start pulse in EVAL or DONE -> ignored, exactly one dout_valid.

Source files
------------

// File: rtl/dual_rail_pkg.sv
// Shared definitions for the dual-rail collector: FSM state encoding,
// fault codes and the counter width helper.
package dual_rail_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRECHARGE = 3'd1;
    localparam logic [2:0] ST_EVAL      = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_EVAL_TO  = 2'b10;
    localparam logic [1:0] FC_PRE_TO   = 2'b11;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int cnt_width(input int pre_cycles, input int timeout);
        int m;
        m = (pre_cycles > timeout) ? pre_cycles : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dual_rail_detect.sv
// Combinational decode of a dual-rail word: all bits valid, all-spacer,
// or any bit carrying the forbidden 11 code.
module dual_rail_detect #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din_t,
    input  logic [WIDTH-1:0] din_f,
    output logic             complete,
    output logic             zero,
    output logic             illegal
);

    assign complete = &(din_t ^ din_f);
    assign zero     = ~|(din_t | din_f);
    assign illegal  = |(din_t & din_f);

endmodule

// File: rtl/dual_rail_collector.sv
// Sequences precharge/evaluate for an upstream dual-rail network and
// registers the evaluated word as single-rail data, trapping faults.
//
// state      | meaning
// IDLE       | waiting for start, rails precharged
// PRECHARGE  | waiting for PRE_CYCLES consecutive all-zero words
// EVAL       | precharge released, waiting for a complete word
// DONE       | dout just updated, dout_valid high for this cycle
// FAULT      | illegal code or timeout seen, held until clear
module dual_rail_collector
    import dual_rail_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRE_CYCLES = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] din_t,
    input  logic [WIDTH-1:0] din_f,
    output logic             precharge,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam int CW = cnt_width(PRE_CYCLES, TIMEOUT);
    localparam logic [CW-1:0] ZLAST = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [2:0]       state;
    logic [CW-1:0]    zcnt;
    logic [CW-1:0]    tcnt;
    logic [WIDTH-1:0] dout_q;
    logic [1:0]       fault_code_q;

    logic complete;
    logic zero;
    logic illegal;

    dual_rail_detect #(
        .WIDTH (WIDTH)
    ) u_detect (
        .din_t    (din_t),
        .din_f    (din_f),
        .complete (complete),
        .zero     (zero),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            zcnt         <= '0;
            tcnt         <= '0;
            dout_q       <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PRECHARGE;
                        zcnt  <= '0;
                        tcnt  <= '0;
                    end
                end
                ST_PRECHARGE: begin
                    if (zero && (zcnt == ZLAST)) begin
                        state <= ST_EVAL;
                        zcnt  <= '0;
                        tcnt  <= '0;
                    end else begin
                        zcnt <= zero ? (zcnt + ONE) : '0;
                        if (tcnt == TLAST) begin
                            state        <= ST_FAULT;
                            fault_code_q <= FC_PRE_TO;
                        end else begin
                            tcnt <= tcnt + ONE;
                        end
                    end
                end
                ST_EVAL: begin
                    // An 11 code is a fault even if the rest of the word completed.
                    if (illegal) begin
                        state        <= ST_FAULT;
                        fault_code_q <= FC_ILLEGAL;
                    end else if (complete) begin
                        state  <= ST_DONE;
                        dout_q <= din_t;
                    end else if (tcnt == TLAST) begin
                        state        <= ST_FAULT;
                        fault_code_q <= FC_EVAL_TO;
                    end else begin
                        tcnt <= tcnt + ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_FAULT: begin
                    if (clear) begin
                        state        <= ST_IDLE;
                        fault_code_q <= FC_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign precharge  = (state != ST_EVAL);
    assign dout       = dout_q;
    assign dout_valid = (state == ST_DONE);
    assign busy       = (state == ST_PRECHARGE) || (state == ST_EVAL) || (state == ST_DONE);
    assign fault      = (state == ST_FAULT);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_dual_rail_collector.sv
// Self-checking bench for dual_rail_collector: directed scenarios plus
// randomized evaluations predicted from per-bit arrival times.
module tb_dual_rail_collector;
    import dual_rail_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] din_t = 8'h00;
    logic [7:0] din_f = 8'h00;

    logic       precharge, dout_valid, busy, fault;
    logic [7:0] dout;
    logic [1:0] fault_code;
    logic       precharge3, dout_valid3, busy3, fault3;
    logic [7:0] dout3;
    logic [1:0] fault_code3;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_dout = 8'h00;

    always #5 clk = ~clk;

    dual_rail_collector #(.WIDTH(8), .PRE_CYCLES(1), .TIMEOUT(TMO)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .clear (clear),
        .din_t (din_t), .din_f (din_f), .precharge (precharge), .dout (dout),
        .dout_valid (dout_valid), .busy (busy), .fault (fault), .fault_code (fault_code)
    );

    dual_rail_collector #(.WIDTH(8), .PRE_CYCLES(3), .TIMEOUT(TMO)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .start (start3), .clear (clear),
        .din_t (din_t), .din_f (din_f), .precharge (precharge3), .dout (dout3),
        .dout_valid (dout_valid3), .busy (busy3), .fault (fault3), .fault_code (fault_code3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input logic pc, input logic [7:0] d,
                           input logic dv, input logic b, input logic f, input logic [1:0] fc);
        check({tag, " precharge"},  8'(precharge),  8'(pc));
        check({tag, " dout"},       dout,           d);
        check({tag, " dout_valid"}, 8'(dout_valid), 8'(dv));
        check({tag, " busy"},       8'(busy),       8'(b));
        check({tag, " fault"},      8'(fault),      8'(f));
        check({tag, " fault_code"}, 8'(fault_code), 8'(fc));
    endtask

    // One evaluation on the PRE_CYCLES=1 instance. Bit i settles to its value
    // a[i] cycles into EVAL; optionally bit bad_b shows 11 from cycle bad_k on.
    task automatic run_txn(input logic [7:0] d, input int amode, input int bad_k, input int bad_b);
        int a[8];
        int comp;
        int x;
        int k;
        logic [1:0] kind;
        logic [7:0] t;
        logic [7:0] f;
        comp = 0;
        for (int i = 0; i < 8; i++) begin
            case (amode)
                0:       a[i] = 0;
                1:       a[i] = i;
                2:       a[i] = int'($urandom_range(0, 8));
                3:       a[i] = int'($urandom_range(0, 20));
                default: a[i] = 1000;
            endcase
            if (a[i] > comp) comp = a[i];
        end
        if (bad_k <= comp && bad_k <= TMO) begin
            x = bad_k;  kind = FC_ILLEGAL;
        end else if (comp <= TMO) begin
            x = comp;   kind = FC_NONE;
        end else begin
            x = TMO;    kind = FC_EVAL_TO;
        end
        for (int n = 0; n <= x + 3; n++) begin
            start = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            clear = (n >= 1 && n <= x + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            t = 8'h00;
            f = 8'h00;
            if (n >= 2) begin
                k = n - 2;
                for (int i = 0; i < 8; i++) begin
                    if (k >= a[i]) begin
                        if (d[i]) t[i] = 1'b1;
                        else      f[i] = 1'b1;
                    end
                end
                if (k >= bad_k) begin
                    t[bad_b] = 1'b1;
                    f[bad_b] = 1'b1;
                end
            end
            din_t = t;
            din_f = f;
            tick();
            if (n <= x + 1)
                expect1("run", (n == 0), exp_dout, 1'b0, 1'b1, 1'b0, FC_NONE);
            else if (kind == FC_NONE) begin
                if (n == x + 2) expect1("done", 1'b1, d, 1'b1, 1'b1, 1'b0, FC_NONE);
                else            expect1("after_done", 1'b1, d, 1'b0, 1'b0, 1'b0, FC_NONE);
            end else
                expect1("fault", 1'b1, exp_dout, 1'b0, 1'b0, 1'b1, kind);
        end
        start = 1'b0;
        clear = 1'b0;
        din_t = 8'h00;
        din_f = 8'h00;
        if (kind == FC_NONE) begin
            exp_dout = d;
        end else begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            expect1("clear", 1'b1, exp_dout, 1'b0, 1'b0, 1'b0, FC_NONE);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d3;
        int ev;

        // reset state
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        expect1("reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, FC_NONE);
        check("reset3 precharge", 8'(precharge3), 8'h01);
        check("reset3 busy", 8'(busy3), 8'h00);
        rst_n = 1'b1;
        exp_dout = 8'h00;
        tick();

        // nominal, slow arrival, illegal code, eval timeout
        run_txn(8'hA5, 0, 1000, 0);
        run_txn(8'($urandom), 1, 1000, 0);
        run_txn(8'h00, 0, 0, 0);
        run_txn(8'($urandom), 4, 1000, 0);

        // precharge timeout: a non-zero word held through precharge
        start = 1'b1;
        tick();
        start = 1'b0;
        din_t = 8'h01;
        din_f = 8'h00;
        expect1("pre_enter", 1'b1, exp_dout, 1'b0, 1'b1, 1'b0, FC_NONE);
        for (int n = 1; n <= TMO + 1; n++) begin
            tick();
            if (n <= TMO) expect1("pre_wait", 1'b1, exp_dout, 1'b0, 1'b1, 1'b0, FC_NONE);
            else          expect1("pre_timeout", 1'b1, exp_dout, 1'b0, 1'b0, 1'b1, FC_PRE_TO);
        end
        din_t = 8'h00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect1("pre_clear", 1'b1, exp_dout, 1'b0, 1'b0, 1'b0, FC_NONE);

        // reset in the middle of EVAL
        run_txn(8'h3C, 0, 1000, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect1("in_eval", 1'b0, exp_dout, 1'b0, 1'b1, 1'b0, FC_NONE);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect1("mid_reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, FC_NONE);
        rst_n = 1'b1;
        exp_dout = 8'h00;
        tick();
        expect1("post_reset", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, FC_NONE);

        // PRE_CYCLES=3: a non-zero word at precharge sample b restarts the run
        for (int b = 0; b <= 3; b++) begin
            ev = (b == 0) ? 3 : b + 3;
            d3 = 8'($urandom);
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            for (int n = 1; n <= ev; n++) begin
                din_t = (n == b) ? 8'($urandom_range(1, 255)) : 8'h00;
                din_f = 8'h00;
                tick();
                check("pre3 precharge", 8'(precharge3), (n >= ev) ? 8'h00 : 8'h01);
                check("pre3 busy", 8'(busy3), 8'h01);
            end
            din_t = d3;
            din_f = ~d3;
            tick();
            check("pre3 dout_valid", 8'(dout_valid3), 8'h01);
            check("pre3 dout", dout3, d3);
            din_t = 8'h00;
            din_f = 8'h00;
            tick();
            check("pre3 idle dout_valid", 8'(dout_valid3), 8'h00);
            check("pre3 idle fault", 8'(fault3), 8'h00);
        end

        // randomized evaluations, some with an injected 11 code
        for (int r = 0; r < 40; r++) begin
            run_txn(8'($urandom), int'($urandom_range(2, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 1000,
                    int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
